// File: rtl/counter_bcd_mod.sv
// Modulo-N packed-BCD up/down counter with terminal-count output for cascading.
// Q holds DIGITS BCD digits (units in Q[3:0]) and always stays within 0..MODULUS-1.
// TC marks the cycle before a wrap, so it can drive EN of the next stage.
// Optional feature: define CNTBCD_LOAD_EN to add the synchronous parallel load
// (LD, D). Priority is then nCR > LD > EN > hold. Without it, it is nCR > EN > hold.
module counter_bcd_mod #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 60
) (
  input  logic                  CP,
  input  logic                  nCR,
  input  logic                  EN,
  input  logic                  UP,
`ifdef CNTBCD_LOAD_EN
  input  logic                  LD,
  input  logic [4*DIGITS-1:0]   D,
`endif
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC
);

  localparam int unsigned W = 4 * DIGITS;

  // Convert a binary constant into packed BCD at elaboration time.
  function automatic logic [W-1:0] to_bcd(input int unsigned value);
    int unsigned v;
    logic [W-1:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MaxBcd = to_bcd(MODULUS - 1);

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] inc_val, dec_val;
  logic [W-1:0] inc_next, dec_next;
  logic         inc_carry, dec_borrow;
  logic         is_max, is_zero;

  assign is_max  = (q_q == MaxBcd);
  assign is_zero = (q_q == '0);

  // Rippled BCD increment: each digit rolls 9 -> 0 and passes a carry upward.
  always_comb begin
    inc_val   = q_q;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  // Rippled BCD decrement: each digit rolls 0 -> 9 and passes a borrow upward.
  always_comb begin
    dec_val    = q_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dec_borrow) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  // Modulus wrap overrides the plain BCD step at either end of the range.
  assign inc_next = is_max  ? '0     : inc_val;
  assign dec_next = is_zero ? MaxBcd : dec_val;

`ifdef CNTBCD_LOAD_EN
  logic d_digits_ok;
  logic d_valid;

  // A load value is accepted only if every nibble is a decimal digit and it is in range.
  always_comb begin
    d_digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (D[4*i +: 4] > 4'd9) begin
        d_digits_ok = 1'b0;
      end
    end
  end

  // With valid digits, packed-BCD magnitude order matches decimal order.
  assign d_valid = d_digits_ok && (D <= MaxBcd);

  // Next-state select: load beats count, count beats hold.
  always_comb begin
    q_d = q_q;
    if (LD) begin
      q_d = d_valid ? D : '0;
    end else if (EN) begin
      q_d = UP ? inc_next : dec_next;
    end
  end
`else
  // Next-state select: count or hold.
  always_comb begin
    q_d = q_q;
    if (EN) begin
      q_d = UP ? inc_next : dec_next;
    end
  end
`endif

  // Count register; nCR clears it immediately, independent of CP.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  // Terminal count is purely from the current count, EN and UP; load inputs never affect it.
  assign TC = EN & (UP ? is_max : is_zero);

endmodule
